tx_framing_ctrl: RTL and testbench

Sequencer for the TX framing stage. It arbitrates between the TLP source, the DLLP source and the end-of-data-stream request, and emits one dword-wide slot code per cycle. The slot code tells the framing mux whether to place IDL, STP, TLP body, LCRC, SDP+DLLP or EDS on the lane stream. It also latches the length and sequence number that the token builder uses to form the STP token.

---
 rtl/tx_framing_ctrl.sv | 147 ++++++++++++++
 tb/tb_tx_framing_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_framing_ctrl.sv
// TX framing sequencer: arbitrates TLP/DLLP/EDS requests and emits one slot code per cycle,
// latching the length and sequence number used to build the STP token.
module tx_framing_ctrl #(
  parameter int SEQ_NUM_WIDTH  = 12,
  parameter int PACKET_LENGTH  = 11,
  parameter int DLLP_BURST_MAX = 2
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_Tlp_Req,
  input  logic [PACKET_LENGTH-1:0] i_Tlp_Length,
  input  logic [SEQ_NUM_WIDTH-1:0] i_Tlp_Seq,
  input  logic                     i_Dllp_Req,
  input  logic                     i_Eds_Req,
  input  logic                     i_Resume,
  input  logic                     i_Slot_Ready,
  output logic                     o_Slot_Valid,
  output logic [2:0]               o_Slot_Sel,
  output logic                     o_Tlp_Ack,
  output logic                     o_Tlp_Rd,
  output logic                     o_Dllp_Ack,
  output logic                     o_Eds_Done,
  output logic [PACKET_LENGTH-1:0] o_Length,
  output logic [SEQ_NUM_WIDTH-1:0] o_Sequence_number
);

  localparam int BW = (DLLP_BURST_MAX < 1) ? 1 : $clog2(DLLP_BURST_MAX + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    STP   = 3'd1,
    BODY  = 3'd2,
    LCRC  = 3'd3,
    DLLP0 = 3'd4,
    DLLP1 = 3'd5,
    EDS   = 3'd6,
    HALT  = 3'd7
  } state_e;

  state_e                   state_q, state_d;
  logic [PACKET_LENGTH-1:0] body_cnt_q, body_cnt_d;
  logic [PACKET_LENGTH-1:0] length_q, length_d;
  logic [SEQ_NUM_WIDTH-1:0] seq_q, seq_d;
  logic [BW-1:0]            burst_q, burst_d;

  logic slot_valid;
  logic advance;
  logic arb_en;
  logic burst_full;
  logic grant_eds;
  logic grant_dllp;
  logic grant_tlp;

  // Arbitration only happens where a new packet may start: IDLE and the last slot of a packet.
  always_comb begin
    slot_valid = (state_q != HALT);
    advance    = slot_valid & i_Slot_Ready;
    arb_en     = advance & ((state_q == IDLE) | (state_q == LCRC) | (state_q == DLLP1));
    burst_full = (burst_q == BW'(DLLP_BURST_MAX));
    grant_eds  = arb_en & i_Eds_Req;
    grant_dllp = arb_en & ~i_Eds_Req & i_Dllp_Req & ~(i_Tlp_Req & burst_full);
    grant_tlp  = arb_en & ~i_Eds_Req & ~grant_dllp & i_Tlp_Req;
  end

  always_comb begin
    state_d    = state_q;
    body_cnt_d = body_cnt_q;
    length_d   = length_q;
    seq_d      = seq_q;
    burst_d    = burst_q;

    case (state_q)
      IDLE, LCRC, DLLP1: begin
        if (advance) begin
          if (grant_eds)       state_d = EDS;
          else if (grant_dllp) state_d = DLLP0;
          else if (grant_tlp)  state_d = STP;
          else                 state_d = IDLE;
        end
      end
      STP: begin
        if (advance) state_d = (body_cnt_q != '0) ? BODY : LCRC;
      end
      BODY: begin
        if (advance) begin
          body_cnt_d = body_cnt_q - PACKET_LENGTH'(1);
          if (body_cnt_q == PACKET_LENGTH'(1)) state_d = LCRC;
        end
      end
      DLLP0: begin
        if (advance) state_d = DLLP1;
      end
      EDS: begin
        if (advance) state_d = HALT;
      end
      HALT: begin
        if (i_Resume) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (grant_tlp) begin
      length_d   = i_Tlp_Length;
      seq_d      = i_Tlp_Seq;
      body_cnt_d = i_Tlp_Length;
      burst_d    = '0;
    end else if (grant_dllp && i_Tlp_Req && !burst_full) begin
      burst_d = burst_q + BW'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      body_cnt_q <= '0;
      length_q   <= '0;
      seq_q      <= '0;
      burst_q    <= '0;
    end else begin
      state_q    <= state_d;
      body_cnt_q <= body_cnt_d;
      length_q   <= length_d;
      seq_q      <= seq_d;
      burst_q    <= burst_d;
    end
  end

  always_comb begin
    o_Slot_Valid = slot_valid;
    case (state_q)
      STP:     o_Slot_Sel = 3'd1;
      BODY:    o_Slot_Sel = 3'd2;
      LCRC:    o_Slot_Sel = 3'd3;
      DLLP0:   o_Slot_Sel = 3'd4;
      DLLP1:   o_Slot_Sel = 3'd5;
      EDS:     o_Slot_Sel = 3'd6;
      default: o_Slot_Sel = 3'd0;
    endcase
    o_Tlp_Ack         = (state_q == STP)   & i_Slot_Ready;
    o_Tlp_Rd          = (state_q == BODY)  & i_Slot_Ready;
    o_Dllp_Ack        = (state_q == DLLP0) & i_Slot_Ready;
    o_Eds_Done        = (state_q == EDS)   & i_Slot_Ready;
    o_Length          = length_q;
    o_Sequence_number = seq_q;
  end

endmodule

// File: tb/tb_tx_framing_ctrl.sv
// Self-checking bench for tx_framing_ctrl: a slot-queue reference model checks every cycle,
// directed scenarios check slot order, and a randomized phase exercises arbitration and stalls.
module tb_tx_framing_ctrl;

  localparam int SW = 12;
  localparam int LW = 11;
  localparam int BM = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          i_Tlp_Req, i_Dllp_Req, i_Eds_Req, i_Resume, i_Slot_Ready;
  logic [LW-1:0] i_Tlp_Length;
  logic [SW-1:0] i_Tlp_Seq;
  logic          o_Slot_Valid, o_Tlp_Ack, o_Tlp_Rd, o_Dllp_Ack, o_Eds_Done;
  logic [2:0]    o_Slot_Sel;
  logic [LW-1:0] o_Length;
  logic [SW-1:0] o_Sequence_number;

  always #5 clk = ~clk;

  tx_framing_ctrl #(
    .SEQ_NUM_WIDTH (SW),
    .PACKET_LENGTH (LW),
    .DLLP_BURST_MAX(BM)
  ) dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_Tlp_Req        (i_Tlp_Req),
    .i_Tlp_Length     (i_Tlp_Length),
    .i_Tlp_Seq        (i_Tlp_Seq),
    .i_Dllp_Req       (i_Dllp_Req),
    .i_Eds_Req        (i_Eds_Req),
    .i_Resume         (i_Resume),
    .i_Slot_Ready     (i_Slot_Ready),
    .o_Slot_Valid     (o_Slot_Valid),
    .o_Slot_Sel       (o_Slot_Sel),
    .o_Tlp_Ack        (o_Tlp_Ack),
    .o_Tlp_Rd         (o_Tlp_Rd),
    .o_Dllp_Ack       (o_Dllp_Ack),
    .o_Eds_Done       (o_Eds_Done),
    .o_Length         (o_Length),
    .o_Sequence_number(o_Sequence_number)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: the packet in flight is a queue of remaining slot codes.
  int            q[$];
  bit            halted = 1'b0;
  int            burst  = 0;
  int            m_len  = 0;
  int            m_seq  = 0;

  int            trace[$];
  int            n_rd = 0, n_tlp_ack = 0, n_dllp_ack = 0;
  bit            tlp_auto = 1'b0, dllp_auto = 1'b0;

  task automatic check_eq(string tag, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", tag, act, exp);
    end
  endtask

  task automatic check_trace(string tag, int exp[$]);
    check_eq({tag, "_count"}, trace.size(), exp.size());
    foreach (exp[i]) check_eq(tag, (i < trace.size()) ? trace[i] : -1, exp[i]);
  endtask

  task automatic model_step();
    if (!rst_n) begin
      q.delete();
      halted = 1'b0;
      burst  = 0;
      m_len  = 0;
      m_seq  = 0;
      return;
    end
    if (halted) begin
      if (i_Resume) halted = 1'b0;
      return;
    end
    if (!i_Slot_Ready) return;
    if (q.size() != 0) begin
      if (q[0] == 6) halted = 1'b1;
      void'(q.pop_front());
      if (halted || q.size() != 0) return;
    end
    if (i_Eds_Req) begin
      q.push_back(6);
    end else if (i_Dllp_Req && !(i_Tlp_Req && burst == BM)) begin
      q.push_back(4);
      q.push_back(5);
      if (i_Tlp_Req && burst < BM) burst++;
    end else if (i_Tlp_Req) begin
      q.push_back(1);
      repeat (int'(i_Tlp_Length)) q.push_back(2);
      q.push_back(3);
      burst = 0;
      m_len = int'(i_Tlp_Length);
      m_seq = int'(i_Tlp_Seq);
    end
  endtask

  // One clock: check outputs mid-cycle, advance the model, then update requesters after the edge.
  task automatic tick();
    int es;
    bit tlp_acked, dllp_acked, eds_done;
    @(negedge clk);
    es = (halted || q.size() == 0) ? 0 : q[0];
    check_eq("slot_valid", int'(o_Slot_Valid), int'(!halted));
    check_eq("slot_sel",   int'(o_Slot_Sel), es);
    check_eq("tlp_ack",    int'(o_Tlp_Ack),  int'(es == 1 && i_Slot_Ready));
    check_eq("tlp_rd",     int'(o_Tlp_Rd),   int'(es == 2 && i_Slot_Ready));
    check_eq("dllp_ack",   int'(o_Dllp_Ack), int'(es == 4 && i_Slot_Ready));
    check_eq("eds_done",   int'(o_Eds_Done), int'(es == 6 && i_Slot_Ready));
    check_eq("length",     int'(o_Length), m_len);
    check_eq("seq",        int'(o_Sequence_number), m_seq);
    if (o_Slot_Valid && i_Slot_Ready) trace.push_back(int'(o_Slot_Sel));
    n_rd       += int'(o_Tlp_Rd);
    n_tlp_ack  += int'(o_Tlp_Ack);
    n_dllp_ack += int'(o_Dllp_Ack);
    tlp_acked  = (es == 1) && i_Slot_Ready;
    dllp_acked = (es == 4) && i_Slot_Ready;
    eds_done   = (es == 6) && i_Slot_Ready;
    model_step();
    @(posedge clk);
    #1;
    i_Resume = 1'b0;
    if (tlp_acked) begin
      i_Tlp_Req = tlp_auto;
      if (tlp_auto) i_Tlp_Seq = i_Tlp_Seq + SW'(1);
    end
    if (dllp_acked) i_Dllp_Req = dllp_auto;
    if (eds_done) i_Eds_Req = 1'b0;
  endtask

  task automatic clear_counts();
    trace.delete();
    n_rd = 0;
    n_tlp_ack = 0;
    n_dllp_ack = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    i_Tlp_Req = 1'b0;
    i_Tlp_Length = '0;
    i_Tlp_Seq = '0;
    i_Dllp_Req = 1'b0;
    i_Eds_Req = 1'b0;
    i_Resume = 1'b0;
    i_Slot_Ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    check_eq("rst_valid", int'(o_Slot_Valid), 1);
    check_eq("rst_sel", int'(o_Slot_Sel), 0);
    check_eq("rst_len", int'(o_Length), 0);
    check_eq("rst_seq", int'(o_Sequence_number), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Single TLP, length 4
    clear_counts();
    i_Tlp_Req = 1'b1;
    i_Tlp_Length = LW'(4);
    i_Tlp_Seq = SW'(12'h123);
    repeat (8) tick();
    check_trace("tlp4", '{0, 1, 2, 2, 2, 2, 3, 0});
    check_eq("tlp4_len", int'(o_Length), 4);
    check_eq("tlp4_seq", int'(o_Sequence_number), 'h123);
    check_eq("tlp4_rd", n_rd, 4);
    check_eq("tlp4_ack", n_tlp_ack, 1);

    // Zero-length TLP
    clear_counts();
    i_Tlp_Req = 1'b1;
    i_Tlp_Length = '0;
    i_Tlp_Seq = SW'(12'h7);
    repeat (4) tick();
    check_trace("tlp0", '{0, 1, 3, 0});
    check_eq("tlp0_rd", n_rd, 0);

    // DLLP burst limit against a waiting TLP
    clear_counts();
    tlp_auto = 1'b1;
    dllp_auto = 1'b1;
    i_Tlp_Req = 1'b1;
    i_Tlp_Length = LW'(1);
    i_Dllp_Req = 1'b1;
    repeat (15) tick();
    check_trace("burst", '{0, 4, 5, 4, 5, 1, 2, 3, 4, 5, 4, 5, 1, 2, 3});
    tlp_auto = 1'b0;
    dllp_auto = 1'b0;
    repeat (20) tick();

    // EDS raised during TLP body, DLLP waits until after resume
    clear_counts();
    i_Tlp_Req = 1'b1;
    i_Tlp_Length = LW'(4);
    i_Tlp_Seq = SW'(12'h55);
    repeat (3) tick();
    i_Eds_Req = 1'b1;
    i_Dllp_Req = 1'b1;
    repeat (7) tick();
    check_trace("eds", '{0, 1, 2, 2, 2, 2, 3, 6});
    check_eq("halt_valid", int'(o_Slot_Valid), 0);
    clear_counts();
    i_Resume = 1'b1;
    repeat (4) tick();
    check_trace("resume", '{0, 4, 5});

    // Stalls during STP and BODY
    clear_counts();
    i_Tlp_Req = 1'b1;
    i_Tlp_Length = LW'(3);
    i_Tlp_Seq = SW'(12'h9a);
    tick();
    i_Slot_Ready = 1'b0;
    repeat (3) tick();
    i_Slot_Ready = 1'b1;
    repeat (2) tick();
    i_Slot_Ready = 1'b0;
    repeat (3) tick();
    i_Slot_Ready = 1'b1;
    repeat (4) tick();
    check_trace("stall", '{0, 1, 2, 2, 2, 3, 0});
    check_eq("stall_rd", n_rd, 3);
    check_eq("stall_ack", n_tlp_ack, 1);

    // Reset while in DLLP1, then DLLP re-presented
    i_Dllp_Req = 1'b1;
    repeat (2) tick();
    check_eq("pre_rst_sel", int'(o_Slot_Sel), 5);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_eq("post_rst_sel", int'(o_Slot_Sel), 0);
    check_eq("post_rst_valid", int'(o_Slot_Valid), 1);
    check_eq("post_rst_len", int'(o_Length), 0);
    check_eq("post_rst_seq", int'(o_Sequence_number), 0);
    clear_counts();
    i_Dllp_Req = 1'b1;
    repeat (4) tick();
    check_trace("redllp", '{0, 4, 5, 0});
    check_eq("redllp_ack", n_dllp_ack, 1);

    // Maximum length TLP
    clear_counts();
    i_Tlp_Req = 1'b1;
    i_Tlp_Length = '1;
    i_Tlp_Seq = SW'(12'hfff);
    repeat (2052) tick();
    check_eq("maxlen_rd", n_rd, 2047);
    check_eq("maxlen_ack", n_tlp_ack, 1);
    check_eq("maxlen_len", int'(o_Length), 2047);

    // Randomized traffic with backpressure
    repeat (3000) begin
      i_Slot_Ready = ($urandom_range(3) != 0);
      if (!i_Tlp_Req && $urandom_range(3) == 0) begin
        i_Tlp_Req = 1'b1;
        i_Tlp_Length = LW'($urandom_range(7));
        i_Tlp_Seq = SW'($urandom);
      end
      if (!i_Dllp_Req && $urandom_range(2) == 0) i_Dllp_Req = 1'b1;
      if (!i_Eds_Req && $urandom_range(150) == 0) i_Eds_Req = 1'b1;
      i_Resume = ($urandom_range(halted ? 3 : 40) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
